// File: rtl/frame_stream_sequencer.sv
// frame_stream_sequencer
// ----------------------
// Walks one image frame through a fixed-latency pixel datapath. Pixels are
// popped from a first-word-fall-through input FIFO, issued to the datapath
// with start-of-frame / end-of-line tags, tracked through a valid pipe that
// mirrors the datapath latency, and pushed into the output FIFO. Issued and
// retired pixel counts make the frame end exactly after the last write.
//
// Ports:
//   clock, reset         rising-edge clock, synchronous active-high reset
//   start                begin one frame (only honoured in IDLE)
//   in_empty, in_dout    input FIFO status and FWFT data
//   in_rd_en             input FIFO pop (same cycle as data use)
//   dp_din, dp_ce        pixel and clock-enable to the datapath
//   dp_sof, dp_eol       tags for the issued pixel
//   dp_dout              datapath result, PIPE_LAT enabled cycles after issue
//   out_full             output FIFO full; stalls the whole pipe
//   out_wr_en, out_din   output FIFO push and data
//   busy                 frame in progress (RUN or DRAIN)
//   done                 one-cycle pulse after the last pixel is written
//   frame_count          completed frames, wraps at 16 bits

module frame_stream_sequencer #(
  parameter int DWIDTH     = 24,
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 540,
  parameter int PIPE_LAT   = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_empty,
  input  logic [DWIDTH-1:0] in_dout,
  output logic              in_rd_en,
  output logic [DWIDTH-1:0] dp_din,
  output logic              dp_ce,
  output logic              dp_sof,
  output logic              dp_eol,
  input  logic [DWIDTH-1:0] dp_dout,
  input  logic              out_full,
  output logic              out_wr_en,
  output logic [DWIDTH-1:0] out_din,
  output logic              busy,
  output logic              done,
  output logic [15:0]       frame_count
);

  localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int XW    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int YW    = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [CW-1:0] TOTAL_C = CW'(TOTAL);
  localparam logic [XW-1:0] X_LAST  = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [CW-1:0]       issued_q, issued_d;
  logic [CW-1:0]       retired_q, retired_d;
  logic [PIPE_LAT-1:0] vpipe_q, vpipe_d;
  logic [15:0]         frame_count_q, frame_count_d;

  // Handshake and tag outputs decoded from state and current position.
  always_comb begin
    busy        = (state_q == S_RUN) || (state_q == S_DRAIN);
    // Only the output FIFO can stall; an empty input just inserts bubbles.
    dp_ce       = busy & ~out_full;
    // FWFT input: the pop and the use of in_dout happen in the same cycle.
    in_rd_en    = (state_q == S_RUN) & dp_ce & ~in_empty;
    dp_din      = in_dout;
    dp_sof      = in_rd_en & (x_q == '0) & (y_q == '0);
    dp_eol      = in_rd_en & (x_q == X_LAST);
    out_wr_en   = dp_ce & vpipe_q[PIPE_LAT-1];
    out_din     = dp_dout;
    done        = (state_q == S_DONE);
    frame_count = frame_count_q;
  end

  // Next-state, position, counter and valid-pipe update.
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    issued_d      = issued_q;
    retired_d     = retired_q;
    vpipe_d       = vpipe_q;
    frame_count_d = frame_count_q;

    // Everything in flight moves only on enabled cycles so the valid pipe
    // stays aligned with the datapath's own pipeline registers.
    if (dp_ce) begin
      vpipe_d   = PIPE_LAT'({vpipe_q, in_rd_en});
      issued_d  = issued_q + CW'(in_rd_en);
      retired_d = retired_q + CW'(out_wr_en);
      if (in_rd_en) begin
        if (x_q == X_LAST) begin
          x_d = '0;
          // Wrap y after the last line so it never overflows its width.
          if (y_q == Y_LAST) begin
            y_d = '0;
          end else begin
            y_d = y_q + YW'(1);
          end
        end else begin
          x_d = x_q + XW'(1);
        end
      end else begin
        x_d = x_q;
      end
    end else begin
      vpipe_d = vpipe_q;
    end

    // Transitions use the post-update counts so a last issue or retire in
    // this cycle is seen immediately.
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          x_d       = '0;
          y_d       = '0;
          issued_d  = '0;
          retired_d = '0;
          vpipe_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (issued_d == TOTAL_C) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        if (retired_d == TOTAL_C) begin
          state_d       = S_DONE;
          frame_count_d = frame_count_q + 16'd1;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and counter registers; reset abandons any frame in progress.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      x_q           <= '0;
      y_q           <= '0;
      issued_q      <= '0;
      retired_q     <= '0;
      vpipe_q       <= '0;
      frame_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      issued_q      <= issued_d;
      retired_q     <= retired_d;
      vpipe_q       <= vpipe_d;
      frame_count_q <= frame_count_d;
    end
  end

endmodule
